// File: rtl/rv32i_types.sv
// -----------------------------------------------------------------------------
// rv32i_types
// Shared types for the RV32IM out-of-order core. The branch checkpoint
// snapshot struct holds the recovery state captured at each branch dispatch:
// ROB tail, free-list head and a full RAT image.
// -----------------------------------------------------------------------------
package rv32i_types;

    // Branch-mask width: one bit per in-flight branch / checkpoint slot.
    localparam int BMASK_W        = 4;

    // Snapshot field widths for the default core configuration.
    localparam int CKPT_ROB_IDX_W = 5;   // clog2(32 ROB entries)
    localparam int CKPT_FL_IDX_W  = 6;   // clog2(64 free-list entries)
    localparam int CKPT_ARCH_REGS = 32;
    localparam int CKPT_PREG_IDX  = 6;

    typedef logic [CKPT_PREG_IDX-1:0] preg_idx_t;

    typedef struct packed {
        logic [CKPT_ROB_IDX_W-1:0]           rob_tail;
        logic [CKPT_FL_IDX_W-1:0]            fl_head;
        preg_idx_t [CKPT_ARCH_REGS-1:0]      rat;
    } br_ckpt_t;

endpackage

// File: rtl/br_ckpt_mem.sv
// -----------------------------------------------------------------------------
// br_ckpt_mem
// Payload storage for the branch checkpoint table: DEPTH entries of W bits,
// one synchronous write port and one asynchronous read port. The payload is
// deliberately not reset; only the valid bookkeeping in the parent is.
//   clk    in  : clock
//   we     in  : write enable
//   waddr  in  : write slot
//   wdata  in  : write payload
//   raddr  in  : read slot
//   rdata  out : read payload (combinational)
// -----------------------------------------------------------------------------
module br_ckpt_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/br_checkpoint.sv
// -----------------------------------------------------------------------------
// br_checkpoint
// Branch checkpoint table. Snapshots recovery state on branch dispatch and,
// on branch resolution, produces the registered resolution broadcast plus the
// restore state for a mispredict.
//   clk, rst                 : clock, asynchronous active-high reset
//   ckpt_we/bit/parent       : dispatch strobe, target slot, older-branch mask
//   ckpt_rob_tail/fl_head/rat: snapshot payload
//   res_valid/bit/mispred    : resolution from the branch unit
//   br_mispred/br_corpred    : one-cycle resolution pulses
//   br_bmask                 : surviving mask on mispredict, else 0
//   br_bit                   : resolved slot
//   rst_rob_tail/fl_head/rat : restore state (meaningful with br_mispred)
//   ckpt_live                : per-slot valid vector
// -----------------------------------------------------------------------------
module br_checkpoint
    import rv32i_types::*;
#(
    parameter int BMASK_DEPTH = BMASK_W,
    parameter int ROB_DEPTH   = 32,
    parameter int FREE_DEPTH  = 64,
    parameter int ARCH_REGS   = CKPT_ARCH_REGS,
    parameter int PREG_IDX    = CKPT_PREG_IDX
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ckpt_we,
    input  logic [$clog2(BMASK_DEPTH)-1:0]    ckpt_bit,
    input  logic [BMASK_DEPTH-1:0]            ckpt_parent,
    input  logic [$clog2(ROB_DEPTH)-1:0]      ckpt_rob_tail,
    input  logic [$clog2(FREE_DEPTH)-1:0]     ckpt_fl_head,
    input  logic [ARCH_REGS*PREG_IDX-1:0]     ckpt_rat,
    input  logic                              res_valid,
    input  logic [$clog2(BMASK_DEPTH)-1:0]    res_bit,
    input  logic                              res_mispred,
    output logic                              br_mispred,
    output logic                              br_corpred,
    output logic [BMASK_DEPTH-1:0]            br_bmask,
    output logic [$clog2(BMASK_DEPTH)-1:0]    br_bit,
    output logic [$clog2(ROB_DEPTH)-1:0]      rst_rob_tail,
    output logic [$clog2(FREE_DEPTH)-1:0]     rst_fl_head,
    output logic [ARCH_REGS*PREG_IDX-1:0]     rst_rat,
    output logic [BMASK_DEPTH-1:0]            ckpt_live
);

    localparam int B     = $clog2(BMASK_DEPTH);
    localparam int RT_W  = $clog2(ROB_DEPTH);
    localparam int FH_W  = $clog2(FREE_DEPTH);
    localparam int RAT_W = ARCH_REGS * PREG_IDX;

    logic [BMASK_DEPTH-1:0] valid_reg, valid_next;
    logic [BMASK_DEPTH-1:0] parent_reg  [BMASK_DEPTH];
    logic [BMASK_DEPTH-1:0] parent_next [BMASK_DEPTH];

    logic                   res_hit, mis_hit, cor_hit, wr_en;
    logic [BMASK_DEPTH-1:0] res_onehot, cor_clear;
    br_ckpt_t               wr_data, rd_data;

    logic                   br_mispred_reg, br_corpred_reg;
    logic [BMASK_DEPTH-1:0] br_bmask_reg;
    logic [B-1:0]           br_bit_reg;
    logic [RT_W-1:0]        rst_rob_tail_reg;
    logic [FH_W-1:0]        rst_fl_head_reg;
    logic [RAT_W-1:0]       rst_rat_reg;

    // Resolutions of already-invalid slots (squashed wrong-path branches)
    // are dropped here, so they neither pulse nor touch the table.
    assign res_hit    = res_valid && valid_reg[res_bit];
    assign mis_hit    = res_hit && res_mispred;
    assign cor_hit    = res_hit && !res_mispred;
    // A branch dispatched alongside a mispredict is younger, hence wrong-path.
    assign wr_en      = ckpt_we && !mis_hit;
    assign res_onehot = BMASK_DEPTH'(1) << res_bit;
    assign cor_clear  = cor_hit ? res_onehot : '0;

    assign wr_data.rob_tail = ckpt_rob_tail;
    assign wr_data.fl_head  = ckpt_fl_head;
    assign wr_data.rat      = ckpt_rat;

    generate
        for (genvar gi = 0; gi < BMASK_DEPTH; gi++) begin : g_slot
            localparam logic [B-1:0]           SLOT = B'(gi);
            localparam logic [BMASK_DEPTH-1:0] SELF = BMASK_DEPTH'(1) << gi;
            logic load, kill;

            assign load = wr_en && (ckpt_bit == SLOT);
            // Resolved slot always retires; on mispredict every younger
            // dependant (parent bit set) is squashed with it.
            assign kill = (res_hit && (res_bit == SLOT))
                       || (mis_hit && parent_reg[gi][res_bit]);
            assign valid_next[gi]  = load | (valid_reg[gi] & ~kill);
            // A correct resolution in the same cycle as dispatch must not
            // leave a stale bit in the new slot's parent mask.
            assign parent_next[gi] = load ? (ckpt_parent & ~cor_clear & ~SELF)
                                          : (parent_reg[gi] & ~cor_clear);
        end
    endgenerate

    br_ckpt_mem #(
        .DEPTH (BMASK_DEPTH),
        .W     ($bits(br_ckpt_t))
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (ckpt_bit),
        .wdata (wr_data),
        .raddr (res_bit),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg        <= '0;
            parent_reg       <= '{default: '0};
            br_mispred_reg   <= 1'b0;
            br_corpred_reg   <= 1'b0;
            br_bmask_reg     <= '0;
            br_bit_reg       <= '0;
            rst_rob_tail_reg <= '0;
            rst_fl_head_reg  <= '0;
            rst_rat_reg      <= '0;
        end else begin
            valid_reg        <= valid_next;
            parent_reg       <= parent_next;
            br_mispred_reg   <= mis_hit;
            br_corpred_reg   <= cor_hit;
            br_bmask_reg     <= mis_hit ? parent_reg[res_bit] : '0;
            br_bit_reg       <= res_hit ? res_bit : '0;
            rst_rob_tail_reg <= mis_hit ? rd_data.rob_tail : '0;
            rst_fl_head_reg  <= mis_hit ? rd_data.fl_head  : '0;
            rst_rat_reg      <= mis_hit ? rd_data.rat      : '0;
        end
    end

    // Dispatching into a live slot means the allocator handed out a busy bit.
    assert property (@(posedge clk) disable iff (rst)
        (wr_en && !(cor_hit && (res_bit == ckpt_bit))) |-> !valid_reg[ckpt_bit]);

    assign br_mispred   = br_mispred_reg;
    assign br_corpred   = br_corpred_reg;
    assign br_bmask     = br_bmask_reg;
    assign br_bit       = br_bit_reg;
    assign rst_rob_tail = rst_rob_tail_reg;
    assign rst_fl_head  = rst_fl_head_reg;
    assign rst_rat      = rst_rat_reg;
    assign ckpt_live    = valid_reg;

endmodule

// File: tb/tb_br_checkpoint.sv
// -----------------------------------------------------------------------------
// tb_br_checkpoint
// Directed scoreboard bench for br_checkpoint. Stimulus pushes the expected
// resolution broadcast into a queue; a monitor pops and compares on every
// pulse. ckpt_live and reset behaviour are checked inline.
// -----------------------------------------------------------------------------
module tb_br_checkpoint;

    localparam int BD   = 4;
    localparam int B    = 2;
    localparam int RTW  = 5;
    localparam int FHW  = 6;
    localparam int RATW = 192;

    logic            clk = 1'b0;
    logic            rst;
    logic            ckpt_we;
    logic [B-1:0]    ckpt_bit;
    logic [BD-1:0]   ckpt_parent;
    logic [RTW-1:0]  ckpt_rob_tail;
    logic [FHW-1:0]  ckpt_fl_head;
    logic [RATW-1:0] ckpt_rat;
    logic            res_valid;
    logic [B-1:0]    res_bit;
    logic            res_mispred;
    logic            br_mispred, br_corpred;
    logic [BD-1:0]   br_bmask;
    logic [B-1:0]    br_bit;
    logic [RTW-1:0]  rst_rob_tail;
    logic [FHW-1:0]  rst_fl_head;
    logic [RATW-1:0] rst_rat;
    logic [BD-1:0]   ckpt_live;

    br_checkpoint #(
        .BMASK_DEPTH (4),
        .ROB_DEPTH   (32),
        .FREE_DEPTH  (64),
        .ARCH_REGS   (32),
        .PREG_IDX    (6)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ckpt_we       (ckpt_we),
        .ckpt_bit      (ckpt_bit),
        .ckpt_parent   (ckpt_parent),
        .ckpt_rob_tail (ckpt_rob_tail),
        .ckpt_fl_head  (ckpt_fl_head),
        .ckpt_rat      (ckpt_rat),
        .res_valid     (res_valid),
        .res_bit       (res_bit),
        .res_mispred   (res_mispred),
        .br_mispred    (br_mispred),
        .br_corpred    (br_corpred),
        .br_bmask      (br_bmask),
        .br_bit        (br_bit),
        .rst_rob_tail  (rst_rob_tail),
        .rst_fl_head   (rst_fl_head),
        .rst_rat       (rst_rat),
        .ckpt_live     (ckpt_live)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            mis;
        logic            cor;
        logic [BD-1:0]   bmask;
        logic [B-1:0]    bitv;
        logic [RTW-1:0]  tail;
        logic [FHW-1:0]  head;
        logic [RATW-1:0] rat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [RATW-1:0] make_rat(input int seed);
        logic [RATW-1:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i*6 +: 6] = 6'((seed * 7 + i * 3) & 63);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [RATW-1:0] act,
                         input logic [RATW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic push_exp(input logic mis, input logic [BD-1:0] bmask,
                            input logic [B-1:0] b, input logic [RTW-1:0] tail,
                            input logic [FHW-1:0] head, input logic [RATW-1:0] rat);
        exp_t e;
        e.mis = mis; e.cor = !mis; e.bmask = bmask; e.bitv = b;
        e.tail = tail; e.head = head; e.rat = rat;
        sb.push_back(e);
    endtask

    // Monitor: every pulse must match the oldest expected broadcast.
    always @(negedge clk) begin
        if (!rst && (br_mispred === 1'b1 || br_corpred === 1'b1)) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pulse: got mispred=%b corpred=%b bit=%0d expected no pulse at %0t",
                         br_mispred, br_corpred, br_bit, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_mispred", RATW'(br_mispred), RATW'(e.mis));
                check("pulse_corpred", RATW'(br_corpred), RATW'(e.cor));
                check("pulse_bit",     RATW'(br_bit),     RATW'(e.bitv));
                check("pulse_bmask",   RATW'(br_bmask),   RATW'(e.bmask));
                if (e.mis) begin
                    check("rst_rob_tail", RATW'(rst_rob_tail), RATW'(e.tail));
                    check("rst_fl_head",  RATW'(rst_fl_head),  RATW'(e.head));
                    check("rst_rat",      rst_rat,             e.rat);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ckpt_we = 0; ckpt_bit = '0; ckpt_parent = '0; ckpt_rob_tail = '0;
        ckpt_fl_head = '0; ckpt_rat = '0;
        res_valid = 0; res_bit = '0; res_mispred = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic dispatch(input logic [B-1:0] b, input logic [BD-1:0] parent,
                            input logic [RTW-1:0] tail, input logic [FHW-1:0] head,
                            input int seed);
        ckpt_we = 1; ckpt_bit = b; ckpt_parent = parent;
        ckpt_rob_tail = tail; ckpt_fl_head = head; ckpt_rat = make_rat(seed);
        step();
        ckpt_we = 0;
    endtask

    task automatic resolve(input logic [B-1:0] b, input logic mis);
        res_valid = 1; res_bit = b; res_mispred = mis;
        step();
        res_valid = 0;
    endtask

    task automatic three_slots();
        dispatch(2'd0, 4'b0000, 5'd3,  6'd10, 2);
        dispatch(2'd1, 4'b0001, 5'd7,  6'd20, 3);
        dispatch(2'd2, 4'b0011, 5'd12, 6'd30, 4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst = 1;
        #2;
        // Reset state
        check("reset_mispred", RATW'(br_mispred), RATW'(0));
        check("reset_corpred", RATW'(br_corpred), RATW'(0));
        check("reset_bmask",   RATW'(br_bmask),   RATW'(0));
        check("reset_live",    RATW'(ckpt_live),  RATW'(0));
        check("reset_rat",     rst_rat,           RATW'(0));
        step();
        rst = 0;

        // Single branch, correct prediction
        dispatch(2'd0, 4'b0000, 5'd5, 6'd9, 1);
        check("single_live_after_dispatch", RATW'(ckpt_live), RATW'(4'b0001));
        push_exp(0, 4'b0000, 2'd0, '0, '0, '0);
        resolve(2'd0, 0);
        check("single_live_after_resolve", RATW'(ckpt_live), RATW'(4'b0000));
        step();

        // Nested mispredict on slot 1
        do_reset();
        three_slots();
        check("nested_live", RATW'(ckpt_live), RATW'(4'b0111));
        push_exp(1, 4'b0001, 2'd1, 5'd7, 6'd20, make_rat(3));
        resolve(2'd1, 1);
        check("nested_live_after", RATW'(ckpt_live), RATW'(4'b0001));
        step();

        // Correct slot 0, then back-to-back mispredict slot 2
        do_reset();
        three_slots();
        push_exp(0, 4'b0000, 2'd0, '0, '0, '0);
        resolve(2'd0, 0);
        push_exp(1, 4'b0010, 2'd2, 5'd12, 6'd30, make_rat(4));
        resolve(2'd2, 1);
        check("corr_then_mis_live", RATW'(ckpt_live), RATW'(4'b0010));
        step();

        // Mispredict slot 0 with a same-cycle dispatch to slot 1: dropped
        do_reset();
        dispatch(2'd0, 4'b0000, 5'd1, 6'd2, 5);
        push_exp(1, 4'b0000, 2'd0, 5'd1, 6'd2, make_rat(5));
        ckpt_we = 1; ckpt_bit = 2'd1; ckpt_parent = 4'b0001;
        ckpt_rob_tail = 5'd9; ckpt_fl_head = 6'd11; ckpt_rat = make_rat(6);
        resolve(2'd0, 1);
        ckpt_we = 0;
        check("mis_drops_write_live", RATW'(ckpt_live), RATW'(4'b0000));
        step();

        // Correct slot 0 with same-cycle dispatch to slot 1, parent 0001
        do_reset();
        dispatch(2'd0, 4'b0000, 5'd1, 6'd2, 5);
        push_exp(0, 4'b0000, 2'd0, '0, '0, '0);
        ckpt_we = 1; ckpt_bit = 2'd1; ckpt_parent = 4'b0001;
        ckpt_rob_tail = 5'd9; ckpt_fl_head = 6'd11; ckpt_rat = make_rat(6);
        resolve(2'd0, 0);
        ckpt_we = 0;
        check("corr_with_write_live", RATW'(ckpt_live), RATW'(4'b0010));
        // The stored parent shows up as br_bmask on a mispredict of slot 1.
        push_exp(1, 4'b0000, 2'd1, 5'd9, 6'd11, make_rat(6));
        resolve(2'd1, 1);
        check("corr_with_write_live2", RATW'(ckpt_live), RATW'(4'b0000));
        step();

        // Stale resolution of a squashed slot
        do_reset();
        dispatch(2'd0, 4'b0000, 5'd4, 6'd8, 7);
        dispatch(2'd1, 4'b0001, 5'd6, 6'd12, 8);
        push_exp(1, 4'b0000, 2'd0, 5'd4, 6'd8, make_rat(7));
        resolve(2'd0, 1);
        check("stale_live_after_mis", RATW'(ckpt_live), RATW'(4'b0000));
        resolve(2'd1, 1);
        check("stale_no_mispred", RATW'(br_mispred), RATW'(0));
        check("stale_live", RATW'(ckpt_live), RATW'(4'b0000));
        resolve(2'd1, 0);
        check("stale_no_corpred", RATW'(br_corpred), RATW'(0));
        step();

        // Asynchronous reset mid-pulse with two slots live
        do_reset();
        three_slots();
        res_valid = 1; res_bit = 2'd2; res_mispred = 1;
        @(posedge clk);
        #1;
        res_valid = 0;
        check("midrst_pulse_before", RATW'(br_mispred), RATW'(1));
        check("midrst_live_before",  RATW'(ckpt_live),  RATW'(4'b0011));
        rst = 1;
        #1;
        check("midrst_mispred", RATW'(br_mispred),   RATW'(0));
        check("midrst_bmask",   RATW'(br_bmask),     RATW'(0));
        check("midrst_bit",     RATW'(br_bit),       RATW'(0));
        check("midrst_tail",    RATW'(rst_rob_tail), RATW'(0));
        check("midrst_rat",     rst_rat,             RATW'(0));
        check("midrst_live",    RATW'(ckpt_live),    RATW'(0));
        step();
        rst = 0;
        step();
        check("postrst_mispred", RATW'(br_mispred), RATW'(0));
        step();
        check("postrst_live", RATW'(ckpt_live), RATW'(0));
        step();

        check("scoreboard_drained", RATW'(sb.size()), RATW'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
